pulse_period_meter: RTL and testbench



---
 rtl/pulse_period_meter.sv | 97 +++++++++
 tb/tb_pulse_period_meter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Measures rise-to-rise period and high time of a slow asynchronous pulse train
// in system-clock cycles, with a running edge count and a sticky timeout.
module pulse_period_meter #(
    parameter int CNT_W   = 12,
    parameter int TIMEOUT = 2000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout,
    output logic [7:0]       edge_cnt
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MEASURE = 1'b1;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;

    // s1/s2 resolve metastability; s3 only exists to detect the rising edge of s2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= 8'd0;
        end else if (rise) begin
            edge_cnt <= edge_cnt + 8'd1;
        end
    end

    // period_valid is a valid-only strobe (no ready): high for exactly the one
    // cycle in which period/high_time take a new measurement; the values hold after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            hcnt         <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt     <= ONE_C;
                        hcnt    <= ONE_C;
                        timeout <= 1'b0;
                        state   <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period       <= cnt;
                        high_time    <= hcnt;
                        period_valid <= 1'b1;
                        cnt          <= ONE_C;
                        hcnt         <= ONE_C;
                    end else if (cnt == TIMEOUT_C) begin
                        // A rise landing on this very cycle is still a valid period.
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt  <= cnt + ONE_C;
                        hcnt <= hcnt + {{(CNT_W-1){1'b0}}, s2};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: directed waveforms plus random pulse trains,
// compared every cycle against a model built from sampled-level history.
module tb_pulse_period_meter;

    localparam int CNT_W   = 12;
    localparam int TIMEOUT = 2000;
    localparam int HIST    = 65536;

    logic             clk;
    logic             rst_n;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             timeout;
    logic [7:0]       edge_cnt;

    pulse_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig_in       (sig_in),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .timeout      (timeout),
        .edge_cnt     (edge_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        else
            n_pass++;
    endtask

    // reference model: the input level seen at every active edge is logged;
    // a rise becomes visible two edges after the first high sample.
    bit         samp[HIST];
    int         n_edge     = 0;
    int         reset_edge = 1;
    int         last_rise  = 0;
    bit         measuring  = 0;
    int         exp_period = 0;
    int         exp_high   = 0;
    bit         exp_valid  = 0;
    bit         exp_to     = 0;
    logic [7:0] exp_ecnt   = 0;

    function automatic bit get_samp(input int i);
        return (i >= reset_edge && i < HIST) ? samp[i] : 1'b0;
    endfunction

    function automatic int high_samples(input int from, input int upto);
        int s = 0;
        for (int i = from; i <= upto; i++) s += int'(get_samp(i));
        return s;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            reset_edge = n_edge + 1;
            measuring  = 0;
            exp_period = 0;
            exp_high   = 0;
            exp_valid  = 0;
            exp_to     = 0;
            exp_ecnt   = 0;
        end else begin
            n_edge = n_edge + 1;
            if (n_edge < HIST) samp[n_edge] = sig_in;
            exp_valid = 0;
            if (get_samp(n_edge - 2) && !get_samp(n_edge - 3)) begin
                exp_ecnt = exp_ecnt + 8'd1;
                if (measuring) begin
                    exp_period = n_edge - last_rise;
                    exp_high   = high_samples(last_rise - 2, n_edge - 3);
                    exp_valid  = 1;
                end
                measuring = 1;
                exp_to    = 0;
                last_rise = n_edge;
            end else if (measuring && (n_edge - last_rise) == TIMEOUT) begin
                exp_to    = 1;
                measuring = 0;
            end
        end
        #1;
        check("period",       32'(period),       32'(exp_period));
        check("high_time",    32'(high_time),    32'(exp_high));
        check("period_valid", 32'(period_valid), 32'(exp_valid));
        check("timeout",      32'(timeout),      32'(exp_to));
        check("edge_cnt",     32'(edge_cnt),     32'(exp_ecnt));
    end

    // driver tasks
    task automatic drive(input bit v, input int n);
        repeat (n) begin
            @(negedge clk);
            sig_in = v;
        end
    endtask

    task automatic square(input int hi, input int lo, input int reps);
        repeat (reps) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_period",       32'(period),       32'd0);
        check("rst_high_time",    32'(high_time),    32'd0);
        check("rst_period_valid", 32'(period_valid), 32'd0);
        check("rst_timeout",      32'(timeout),      32'd0);
        check("rst_edge_cnt",     32'(edge_cnt),     32'd0);
        sig_in = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        square(500, 500, 4);
        check("sq_period",   32'(period),    32'd1000);
        check("sq_high",     32'(high_time), 32'd500);
        check("sq_edge_cnt", 32'(edge_cnt),  32'd4);

        square(300, 700, 3);
        check("duty_period", 32'(period),    32'd1000);
        check("duty_high",   32'(high_time), 32'd300);

        drive(1'b0, 2100);
        check("to_set",    32'(timeout), 32'd1);
        check("to_period", 32'(period),  32'd1000);
        square(10, 10, 2);
        check("to_clear",  32'(timeout), 32'd0);
        check("to_next",   32'(period),  32'd20);

        square(5, 1995, 1);
        drive(1'b1, 5);
        drive(1'b0, 10);
        check("lim_period",  32'(period),  32'd2000);
        check("lim_timeout", 32'(timeout), 32'd0);
        drive(1'b0, 1986);
        drive(1'b1, 5);
        drive(1'b0, 10);
        check("over_period", 32'(period), 32'd2000);

        drive(1'b1, 100);
        drive(1'b0, 50);
        do_reset(3);
        square(20, 20, 3);

        do_reset(2);
        square(2, 2, 257);
        drive(1'b0, 5);
        check("wrap_edge_cnt", 32'(edge_cnt), 32'd1);

        for (int k = 0; k < 200; k++) begin
            int len;
            len = ($urandom_range(0, 24) == 0) ? $urandom_range(1990, 2010)
                                                : $urandom_range(1, 60);
            drive(k[0] ? 1'b0 : 1'b1, len);
        end
        drive(1'b0, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        n_checks++;
        $display("FAIL watchdog: bench did not complete, got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
